pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter SERVE_FRAMES, default 60, frames the ball is held centred before a serve.
REQ-002 SHALL have parameter WIN_SCORE, default 9, points that end a game.
REQ-003 SHALL have parameter SPEED_INIT, default 2, ball speed at each serve.
REQ-004 SHALL have parameter SPEED_MAX, default 15, speed ceiling.
REQ-005 SHALL have parameter HITS_PER_STEP, default 4, paddle hits per speed increment.
REQ-006 SHALL have port clk, input, 1, system clock; single clock domain.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port vblank, input, 1, level vertical-blank from the video timing block, synchronous to clk.
REQ-009 SHALL have port start, input, 1, debounced start button, level.
REQ-010 SHALL have port miss_left, input, 1, one-cycle pulse: ball passed the left table edge.
REQ-011 SHALL have port miss_right, input, 1, one-cycle pulse: ball passed the right table edge.
REQ-012 SHALL have port paddle_hit, input, 1, one-cycle pulse: ball struck a paddle.
REQ-013 SHALL have port speed, output, 4, ball speed per frame, to the ball block.
REQ-014 SHALL have port ball_run, output, 1, high when the ball moves.
REQ-015 SHALL have port ball_center, output, 1, high when the ball is held at the centre.
REQ-016 SHALL have port serve_dir, output, 1, serve direction (0 = LEFT, 1 = RIGHT).
REQ-017 SHALL have port score_left, output, 4, left player's score.
REQ-018 SHALL have port score_right, output, 4, right player's score.
REQ-019 SHALL have port game_over, output, 1, high in GAME_OVER.

Function
REQ-020 SHALL derive frame_tick as a one-cycle pulse on the vblank rising edge (vblank & ~vblank_q, both registered).
REQ-021 SHALL implement an FSM with states IDLE, SERVE, PLAY, POINT and GAME_OVER; all outputs SHALL be registered.
REQ-022 IDLE: ball_center=1, ball_run=0; on start=1 it SHALL clear both scores, set serve_dir=RIGHT and go to SERVE.
REQ-023 SERVE: the frame counter SHALL load SERVE_FRAMES-1 on entry and decrement on each frame_tick; on frame_tick with counter=0 the FSM SHALL go to PLAY.
REQ-024 SERVE: ball_center=1, ball_run=0, speed=SPEED_INIT, hit counter cleared.
REQ-025 PLAY: ball_center=0 and ball_run=1.
REQ-026 PLAY, paddle_hit: the hit counter SHALL increment; on reaching HITS_PER_STEP it SHALL clear and speed SHALL increment, saturating at SPEED_MAX.
REQ-027 PLAY, miss_left: score_right SHALL increment and serve_dir SHALL be set to LEFT (toward the scorer's opponent); miss_right is symmetric (score_left++, serve_dir=RIGHT).
REQ-028 If miss_left and miss_right arrive in the same cycle, only miss_left SHALL be honoured.
REQ-029 If a miss and paddle_hit arrive in the same cycle, the miss SHALL win and the hit SHALL be discarded.
REQ-030 After a miss the FSM SHALL enter POINT (ball_run=0, ball_center=0) for exactly one cycle.
REQ-031 POINT SHALL exit to GAME_OVER if either score equals WIN_SCORE, otherwise to SERVE.
REQ-032 Scores SHALL never exceed WIN_SCORE; no wrap SHALL occur.
REQ-033 GAME_OVER: game_over=1, ball_run=0, ball_center=1, scores held; start=1 SHALL return to IDLE.
REQ-034 miss_*/paddle_hit SHALL be ignored outside PLAY, and start SHALL be ignored outside IDLE and GAME_OVER.

Reset
REQ-035 On rst=1 at a clk edge: state=IDLE, scores=0, speed=SPEED_INIT, serve_dir=RIGHT, ball_center=1, ball_run=0, game_over=0, counters=0, vblank_q=0.
REQ-036 Reset mid-game SHALL abort immediately with no pending score update; rst SHALL take priority over all inputs.

Structure
REQ-037 State encodings and the LEFT/RIGHT/UP/DOWN direction constants SHALL live in the shared defs include.
REQ-038 The vblank edge detector SHALL be one sub-module, frame_tick_gen; the rest SHALL stay flat.

Verification
REQ-039 Serve timing: reset, start pulse -> ball_run rises on the 60th frame_tick after entering SERVE, with speed=2.
REQ-040 Speed ramp: in PLAY, 4 paddle_hit pulses -> speed=3; 56 total hits -> speed=15 and it holds at 15.
REQ-041 Scoring: in PLAY, miss_left -> score_right=1, serve_dir=LEFT, one-cycle POINT, then SERVE with speed=2.
REQ-042 Collisions: miss_left+miss_right+paddle_hit in the same cycle -> only score_right increments and the hit counter is unchanged.
REQ-043 Game end: score_left=8, then miss_right -> game_over=1, score_left=9; start -> IDLE, and a second start clears scores.
REQ-044 Reset mid-SERVE with counter=30 -> next cycle IDLE, all outputs at reset values.

Source files
------------

// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the pong game controller.
// Holds the FSM state encoding and the ball direction constants used by the
// controller and by the neighbouring ball/paddle blocks.
package pong_game_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StServe    = 3'd1,
        StPlay     = 3'd2,
        StPoint    = 3'd3,
        StGameOver = 3'd4
    } state_e;

    // Horizontal direction (serve_dir) and vertical direction for the ball block.
    localparam logic DirLeft  = 1'b0;
    localparam logic DirRight = 1'b1;
    localparam logic DirUp    = 1'b0;
    localparam logic DirDown  = 1'b1;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: one-cycle pulse on each rising edge of vblank.
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   vblank     - level vertical blank, synchronous to clk
//   frame_tick - one-cycle pulse when vblank rises
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vblank,
    output logic frame_tick
);

    logic vblank_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vblank_q <= 1'b0;
        end else begin
            vblank_q <= vblank;
        end
    end

    assign frame_tick = vblank & ~vblank_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: sequences serve, play, point scoring and game over,
// and ramps the ball speed with paddle hits.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   vblank                       - level vertical blank (frame timing)
//   start                        - debounced start button (level)
//   miss_left, miss_right        - one-cycle pulses, ball passed a table edge
//   paddle_hit                   - one-cycle pulse, ball struck a paddle
//   speed                        - ball speed per frame
//   ball_run, ball_center        - ball moving / ball held at centre
//   serve_dir                    - serve direction (0 left, 1 right)
//   score_left, score_right      - player scores
//   game_over                    - high in the game-over state
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int unsigned SERVE_FRAMES  = 60,
    parameter int unsigned WIN_SCORE     = 9,
    parameter int unsigned SPEED_INIT    = 2,
    parameter int unsigned SPEED_MAX     = 15,
    parameter int unsigned HITS_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblank,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic       paddle_hit,
    output logic [3:0] speed,
    output logic       ball_run,
    output logic       ball_center,
    output logic       serve_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over
);

    localparam int unsigned FrameW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam int unsigned HitW   = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;

    localparam logic [FrameW-1:0] FrameLoad = FrameW'(SERVE_FRAMES - 1);
    localparam logic [FrameW-1:0] FrameOne  = FrameW'(1);
    localparam logic [HitW-1:0]   HitLast   = HitW'(HITS_PER_STEP - 1);
    localparam logic [HitW-1:0]   HitOne    = HitW'(1);
    localparam logic [3:0]        SpeedInit = 4'(SPEED_INIT);
    localparam logic [3:0]        SpeedMax  = 4'(SPEED_MAX);
    localparam logic [3:0]        WinScore  = 4'(WIN_SCORE);

    state_e            state_q;
    logic [FrameW-1:0] frame_cnt_q;
    logic [HitW-1:0]   hit_cnt_q;
    logic              frame_tick;

    frame_tick_gen u_frame_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .vblank     (vblank),
        .frame_tick (frame_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            frame_cnt_q <= '0;
            hit_cnt_q   <= '0;
            speed       <= SpeedInit;
            ball_run    <= 1'b0;
            ball_center <= 1'b1;
            serve_dir   <= DirRight;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            game_over   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StServe;
                        score_left  <= 4'd0;
                        score_right <= 4'd0;
                        serve_dir   <= DirRight;
                        frame_cnt_q <= FrameLoad;
                        hit_cnt_q   <= '0;
                        speed       <= SpeedInit;
                        ball_center <= 1'b1;
                        ball_run    <= 1'b0;
                    end
                end

                StServe: begin
                    if (frame_tick) begin
                        if (frame_cnt_q == '0) begin
                            state_q     <= StPlay;
                            ball_run    <= 1'b1;
                            ball_center <= 1'b0;
                        end else begin
                            frame_cnt_q <= frame_cnt_q - FrameOne;
                        end
                    end
                end

                StPlay: begin
                    // Priority: miss_left, then miss_right, then paddle_hit.
                    if (miss_left) begin
                        if (score_right != WinScore) begin
                            score_right <= score_right + 4'd1;
                        end
                        serve_dir <= DirLeft;
                        state_q   <= StPoint;
                        ball_run  <= 1'b0;
                    end else if (miss_right) begin
                        if (score_left != WinScore) begin
                            score_left <= score_left + 4'd1;
                        end
                        serve_dir <= DirRight;
                        state_q   <= StPoint;
                        ball_run  <= 1'b0;
                    end else if (paddle_hit) begin
                        if (hit_cnt_q == HitLast) begin
                            hit_cnt_q <= '0;
                            if (speed != SpeedMax) begin
                                speed <= speed + 4'd1;
                            end
                        end else begin
                            hit_cnt_q <= hit_cnt_q + HitOne;
                        end
                    end
                end

                StPoint: begin
                    ball_center <= 1'b1;
                    if ((score_left == WinScore) || (score_right == WinScore)) begin
                        state_q   <= StGameOver;
                        game_over <= 1'b1;
                    end else begin
                        state_q     <= StServe;
                        frame_cnt_q <= FrameLoad;
                        hit_cnt_q   <= '0;
                        speed       <= SpeedInit;
                    end
                end

                StGameOver: begin
                    if (start) begin
                        state_q   <= StIdle;
                        game_over <= 1'b0;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;
    import pong_game_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst, vblank, start, miss_left, miss_right, paddle_hit;
    logic [3:0] speed, score_left, score_right;
    logic       ball_run, ball_center, serve_dir, game_over;

    int n_checks = 0;
    int n_fail   = 0;

    pong_game_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .vblank      (vblank),
        .start       (start),
        .miss_left   (miss_left),
        .miss_right  (miss_right),
        .paddle_hit  (paddle_hit),
        .speed       (speed),
        .ball_run    (ball_run),
        .ball_center (ball_center),
        .serve_dir   (serve_dir),
        .score_left  (score_left),
        .score_right (score_right),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pre_serve;
        logic st, ml, mr, hit;
        int   spd;
        logic run, ctr, dir;
        int   sl, sr;
        logic go;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: outputs are sampled 1 ns after the edge, pulses then dropped.
    task automatic cycle();
        @(posedge clk);
        #1;
        start      = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        paddle_hit = 1'b0;
    endtask

    task automatic check_outs(input string tag, input int spd, input logic run,
                              input logic ctr, input logic dir, input int sl,
                              input int sr, input logic go);
        chk({tag, " speed"}, int'(speed), spd);
        chk({tag, " ball_run"}, int'(ball_run), int'(run));
        chk({tag, " ball_center"}, int'(ball_center), int'(ctr));
        chk({tag, " serve_dir"}, int'(serve_dir), int'(dir));
        chk({tag, " score_left"}, int'(score_left), sl);
        chk({tag, " score_right"}, int'(score_right), sr);
        chk({tag, " game_over"}, int'(game_over), int'(go));
    endtask

    task automatic frame_pulse();
        vblank = 1'b1;
        cycle();
        vblank = 1'b0;
        cycle();
    endtask

    task automatic serve_to_play();
        for (int f = 0; f < 60; f++) frame_pulse();
        chk("serve->play ball_run", int'(ball_run), 1);
        chk("serve->play speed", int'(speed), 2);
    endtask

    task automatic add(input logic ps, input logic st, input logic ml, input logic mr,
                       input logic hit, input int spd, input logic run, input logic ctr,
                       input logic dir, input int sl, input int sr, input logic go);
        vec_t v;
        v.pre_serve = ps; v.st = st; v.ml = ml; v.mr = mr; v.hit = hit;
        v.spd = spd; v.run = run; v.ctr = ctr; v.dir = dir;
        v.sl = sl; v.sr = sr; v.go = go;
        vq.push_back(v);
    endtask

    initial begin
        //   ps st ml mr ht spd run ctr dir sl sr go
        add(0, 0, 0, 0, 1, 2, 1, 0, 1, 0, 0, 0);   // hit 1
        add(0, 0, 0, 0, 1, 2, 1, 0, 1, 0, 0, 0);   // hit 2
        add(0, 0, 0, 0, 1, 2, 1, 0, 1, 0, 0, 0);   // hit 3
        add(0, 0, 0, 0, 1, 3, 1, 0, 1, 0, 0, 0);   // hit 4 -> speed step
        add(0, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0);   // idle in play
        add(0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 1, 0);   // miss_left -> POINT
        add(0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 1, 0);   // SERVE, speed reloaded
        add(0, 1, 0, 0, 0, 2, 0, 1, 0, 0, 1, 0);   // start ignored in SERVE
        add(1, 0, 0, 1, 1, 2, 0, 0, 1, 1, 1, 0);   // miss_right beats hit
        add(0, 0, 0, 0, 0, 2, 0, 1, 1, 1, 1, 0);   // SERVE
        add(0, 0, 1, 0, 0, 2, 0, 1, 1, 1, 1, 0);   // miss ignored in SERVE

        rst = 1'b1; vblank = 1'b0; start = 1'b0;
        miss_left = 1'b0; miss_right = 1'b0; paddle_hit = 1'b0;
        cycle();
        check_outs("reset", 2, 0, 1, DirRight, 0, 0, 0);
        rst = 1'b0;

        // Start is the only way out of IDLE.
        miss_left = 1'b1;
        cycle();
        check_outs("idle ignores miss", 2, 0, 1, DirRight, 0, 0, 0);
        start = 1'b1;
        cycle();
        check_outs("enter serve", 2, 0, 1, DirRight, 0, 0, 0);

        // Ball must start moving exactly on the 60th frame tick.
        for (int f = 1; f <= 60; f++) begin
            vblank = 1'b1;
            cycle();
            chk($sformatf("serve tick %0d ball_run", f), int'(ball_run), (f == 60) ? 1 : 0);
            vblank = 1'b0;
            cycle();
        end
        check_outs("first play", 2, 1, 0, DirRight, 0, 0, 0);

        foreach (vq[i]) begin
            if (vq[i].pre_serve) serve_to_play();
            start      = vq[i].st;
            miss_left  = vq[i].ml;
            miss_right = vq[i].mr;
            paddle_hit = vq[i].hit;
            cycle();
            check_outs($sformatf("vec %0d", i), vq[i].spd, vq[i].run, vq[i].ctr,
                       vq[i].dir, vq[i].sl, vq[i].sr, vq[i].go);
        end

        // Triple collision: only miss_left counts, hit counter untouched.
        serve_to_play();
        for (int h = 0; h < 3; h++) begin
            paddle_hit = 1'b1;
            cycle();
        end
        chk("pre-collision hit_cnt", int'(dut.hit_cnt_q), 3);
        miss_left = 1'b1; miss_right = 1'b1; paddle_hit = 1'b1;
        cycle();
        check_outs("collision point", 2, 0, 0, DirLeft, 1, 2, 0);
        chk("collision hit_cnt", int'(dut.hit_cnt_q), 3);
        cycle();
        check_outs("collision serve", 2, 0, 1, DirLeft, 1, 2, 0);

        // Speed ramp with saturation.
        serve_to_play();
        for (int h = 1; h <= 56; h++) begin
            int exp_spd;
            exp_spd = 2 + h / 4;
            if (exp_spd > 15) exp_spd = 15;
            paddle_hit = 1'b1;
            cycle();
            chk($sformatf("ramp hit %0d speed", h), int'(speed), exp_spd);
        end
        miss_right = 1'b1;
        cycle();
        check_outs("ramp point", 15, 0, 0, DirRight, 2, 2, 0);
        cycle();
        check_outs("ramp serve", 2, 0, 1, DirRight, 2, 2, 0);

        // Run left score up to 8, then the winning point.
        for (int k = 0; k < 6; k++) begin
            serve_to_play();
            miss_right = 1'b1;
            cycle();
            cycle();
        end
        check_outs("score 8", 2, 0, 1, DirRight, 8, 2, 0);
        serve_to_play();
        miss_right = 1'b1;
        cycle();
        check_outs("win point", 2, 0, 0, DirRight, 9, 2, 0);
        cycle();
        check_outs("game over", 2, 0, 1, DirRight, 9, 2, 1);
        miss_right = 1'b1;
        cycle();
        check_outs("game over holds", 2, 0, 1, DirRight, 9, 2, 1);
        start = 1'b1;
        cycle();
        check_outs("back to idle", 2, 0, 1, DirRight, 9, 2, 0);
        start = 1'b1;
        cycle();
        check_outs("restart clears", 2, 0, 1, DirRight, 0, 0, 0);

        // Reset in SERVE with counter at 30.
        for (int f = 0; f < 29; f++) frame_pulse();
        chk("serve counter", int'(dut.frame_cnt_q), 30);
        rst = 1'b1;
        miss_right = 1'b1;
        cycle();
        check_outs("reset mid-serve", 2, 0, 1, DirRight, 0, 0, 0);
        chk("reset counter", int'(dut.frame_cnt_q), 0);
        rst = 1'b0;

        // Reset in PLAY beats a simultaneous miss.
        start = 1'b1;
        cycle();
        serve_to_play();
        miss_left = 1'b1;
        cycle();
        cycle();
        check_outs("pre-reset score", 2, 0, 1, DirLeft, 0, 1, 0);
        serve_to_play();
        rst = 1'b1;
        miss_left = 1'b1;
        cycle();
        check_outs("reset mid-play", 2, 0, 1, DirRight, 0, 0, 0);
        rst = 1'b0;
        cycle();
        check_outs("idle after reset", 2, 0, 1, DirRight, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
